// File: rtl/reg_file_2r1w_sb_pkg.sv
// Shared defaults and helpers for the 2-read/1-write register file.
// Default geometry is 16-bit x 32 entries; address width derives from depth.
package reg_file_2r1w_sb_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDepth = 32;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r = r + 1;
    end
    return r;
  endfunction

  localparam int unsigned DefAddrW = clog2(DefDepth);

endpackage

// File: rtl/reg_file_2r1w_sb_scoreboard.sv
// Per-entry busy scoreboard: reserve sets, write clears (set wins on a tie),
// two hazard lookups and a registered any-busy summary.
module reg_file_scoreboard
  import reg_file_2r1w_sb_pkg::*;
#(
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsvA,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              anyBusy
);

  localparam logic [ADDR_W:0] DepthL = (ADDR_W+1)'(DEPTH);

  logic [DEPTH-1:0] busyR;
  logic [DEPTH-1:0] busyNextS;
  logic [DEPTH-1:0] clrMaskS;
  logic [DEPTH-1:0] setMaskS;
  logic             anyBusyR;

  function automatic logic inRange(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DepthL);
  endfunction

  // Set/clear masks; OR-ing the set mask last lets a new producer supersede the write.
  always_comb begin
    clrMaskS = {DEPTH{1'b0}};
    setMaskS = {DEPTH{1'b0}};
    for (int i = 0; i < int'(DEPTH); i++) begin
      clrMaskS[i] = we && (wa == ADDR_W'(i));
      setMaskS[i] = rsv && (rsvA == ADDR_W'(i)) && !(ZERO_REG && (i == 0));
    end
    busyNextS = (busyR & ~clrMaskS) | setMaskS;
  end

  // Hazard lookups see only registered busy state; a write landing now resolves them.
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    if (inRange(ra1)) begin
      hazard1 = busyR[ra1] & ~(we && (wa == ra1));
    end else begin
      hazard1 = 1'b0;
    end
    if (inRange(ra2)) begin
      hazard2 = busyR[ra2] & ~(we && (wa == ra2));
    end else begin
      hazard2 = 1'b0;
    end
  end

  // Busy bits and their OR, both registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busyR    <= {DEPTH{1'b0}};
      anyBusyR <= 1'b0;
    end else begin
      busyR    <= busyNextS;
      anyBusyR <= |busyNextS;
    end
  end

  assign anyBusy = anyBusyR;

endmodule

// File: rtl/reg_file_2r1w_sb.sv
// Parametrised register file: one write port, two registered read ports with
// write-first bypass, optional hardwired-zero entry 0 and a busy scoreboard.
module reg_file_2r1w_sb
  import reg_file_2r1w_sb_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic              re1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic              rv1,
  output logic              rv2,
  output logic              hz1,
  output logic              hz2,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_a,
  output logic              any_busy
);

  localparam logic [ADDR_W:0] DepthL = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] memR [DEPTH];
  logic [WIDTH-1:0] rd1R, rd2R, rd1NextS, rd2NextS;
  logic             rv1R, rv2R, hz1R, hz2R;
  logic             hz1NextS, hz2NextS, wrOkS;

  // Addressable entry: inside the array and not the hardwired-zero slot.
  function automatic logic addrOk(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DepthL) && !(ZERO_REG && (a == {ADDR_W{1'b0}}));
  endfunction

  assign wrOkS = we && addrOk(wa);

  reg_file_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) uScoreboard (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .wa      (wa),
    .rsv     (rsv),
    .rsvA    (rsv_a),
    .ra1     (ra1),
    .ra2     (ra2),
    .hazard1 (hz1NextS),
    .hazard2 (hz2NextS),
    .anyBusy (any_busy)
  );

  // Port 1 read mux with write-first bypass.
  always_comb begin
    rd1NextS = {WIDTH{1'b0}};
    if (addrOk(ra1)) begin
      if (we && (wa == ra1)) begin
        rd1NextS = wd;
      end else begin
        rd1NextS = memR[ra1];
      end
    end else begin
      rd1NextS = {WIDTH{1'b0}};
    end
  end

  // Port 2 read mux with write-first bypass.
  always_comb begin
    rd2NextS = {WIDTH{1'b0}};
    if (addrOk(ra2)) begin
      if (we && (wa == ra2)) begin
        rd2NextS = wd;
      end else begin
        rd2NextS = memR[ra2];
      end
    end else begin
      rd2NextS = {WIDTH{1'b0}};
    end
  end

  // Storage array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        memR[i] <= {WIDTH{1'b0}};
      end
    end else if (wrOkS) begin
      memR[wa] <= wd;
    end else begin
      memR[wa] <= memR[wa];
    end
  end

  // Read registers: data and hazard hold when the port is idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd1R <= {WIDTH{1'b0}};
      rd2R <= {WIDTH{1'b0}};
      rv1R <= 1'b0;
      rv2R <= 1'b0;
      hz1R <= 1'b0;
      hz2R <= 1'b0;
    end else begin
      rv1R <= re1;
      rv2R <= re2;
      if (re1) begin
        rd1R <= rd1NextS;
        hz1R <= hz1NextS;
      end
      if (re2) begin
        rd2R <= rd2NextS;
        hz2R <= hz2NextS;
      end
    end
  end

  assign rd1 = rd1R;
  assign rd2 = rd2R;
  assign rv1 = rv1R;
  assign rv2 = rv2R;
  assign hz1 = hz1R;
  assign hz2 = hz2R;

endmodule

// File: tb/tb_reg_file_2r1w_sb.sv
// Directed bench for reg_file_2r1w_sb: default instance plus a ZERO_REG=1,
// DEPTH=24 instance; read expectations queue up and are checked after the edge.
module tb_reg_file_2r1w_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, re1, re2, rsv;
  logic [4:0]  wa, ra1, ra2, rsvA;
  logic [15:0] wd, rd1, rd2;
  logic        rv1, rv2, hz1, hz2, anyBusy;
  logic        weZ, re1Z, re2Z, rsvZ;
  logic [4:0]  waZ, ra1Z, ra2Z, rsvAZ;
  logic [15:0] wdZ, rd1Z, rd2Z;
  logic        rv1Z, rv2Z, hz1Z, hz2Z, anyBusyZ;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          port;
    logic [15:0] data;
    logic        hz;
  } expT;
  expT expQ[$];

  always #5 clk = ~clk;

  reg_file_2r1w_sb dut (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .re1(re1), .re2(re2), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2), .rv1(rv1), .rv2(rv2), .hz1(hz1), .hz2(hz2),
    .rsv(rsv), .rsv_a(rsvA), .any_busy(anyBusy)
  );

  reg_file_2r1w_sb #(.WIDTH(16), .DEPTH(24), .ADDR_W(5), .ZERO_REG(1'b1)) dutZ (
    .clk(clk), .reset(reset), .we(weZ), .wa(waZ), .wd(wdZ),
    .re1(re1Z), .re2(re2Z), .ra1(ra1Z), .ra2(ra2Z),
    .rd1(rd1Z), .rd2(rd2Z), .rv1(rv1Z), .rv2(rv2Z), .hz1(hz1Z), .hz2(hz2Z),
    .rsv(rsvZ), .rsv_a(rsvAZ), .any_busy(anyBusyZ)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expectRd(input int port, input logic [15:0] d, input logic h, input string tag);
    expT e;
    e.tag = tag; e.port = port; e.data = d; e.hz = h;
    expQ.push_back(e);
  endtask

  task automatic idle();
    we = 1'b0; re1 = 1'b0; re2 = 1'b0; rsv = 1'b0;
    wa = 5'd0; ra1 = 5'd0; ra2 = 5'd0; rsvA = 5'd0; wd = 16'h0000;
    weZ = 1'b0; re1Z = 1'b0; re2Z = 1'b0; rsvZ = 1'b0;
    waZ = 5'd0; ra1Z = 5'd0; ra2Z = 5'd0; rsvAZ = 5'd0; wdZ = 16'h0000;
  endtask

  task automatic tick();
    expT e;
    @(posedge clk);
    #1;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      case (e.port)
        1: begin
          check({e.tag, ".rv1"}, 16'(rv1), 16'd1);
          check({e.tag, ".rd1"}, rd1, e.data);
          check({e.tag, ".hz1"}, 16'(hz1), 16'(e.hz));
        end
        2: begin
          check({e.tag, ".rv2"}, 16'(rv2), 16'd1);
          check({e.tag, ".rd2"}, rd2, e.data);
          check({e.tag, ".hz2"}, 16'(hz2), 16'(e.hz));
        end
        3: begin
          check({e.tag, ".rv1z"}, 16'(rv1Z), 16'd1);
          check({e.tag, ".rd1z"}, rd1Z, e.data);
          check({e.tag, ".hz1z"}, 16'(hz1Z), 16'(e.hz));
        end
        default: begin
          check({e.tag, ".rv2z"}, 16'(rv2Z), 16'd1);
          check({e.tag, ".rd2z"}, rd2Z, e.data);
          check({e.tag, ".hz2z"}, 16'(hz2Z), 16'(e.hz));
        end
      endcase
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #12;
    check("rst.rd1", rd1, 16'h0000);
    check("rst.rd2", rd2, 16'h0000);
    check("rst.rv1", 16'(rv1), 16'd0);
    check("rst.rv2", 16'(rv2), 16'd0);
    check("rst.hz1", 16'(hz1), 16'd0);
    check("rst.busy", 16'(anyBusy), 16'd0);
    check("rst.busyz", 16'(anyBusyZ), 16'd0);
    reset = 1'b0;

    // 1: every address reads zero on both ports
    for (int a = 0; a < 32; a++) begin
      re1 = 1'b1; ra1 = 5'(a); re2 = 1'b1; ra2 = 5'(a);
      expectRd(1, 16'h0000, 1'b0, "t1");
      expectRd(2, 16'h0000, 1'b0, "t1");
      tick();
    end

    // 2: plain writes then dual read
    we = 1'b1; wa = 5'd0; wd = 16'h1232; tick();
    we = 1'b1; wa = 5'd1; wd = 16'h1263; tick();
    re1 = 1'b1; ra1 = 5'd0; re2 = 1'b1; ra2 = 5'd1;
    expectRd(1, 16'h1232, 1'b0, "t2");
    expectRd(2, 16'h1263, 1'b0, "t2");
    tick();

    // 3: bypass, follow-up read, then idle port holds data
    we = 1'b1; wa = 5'd5; wd = 16'hBEEF; re1 = 1'b1; ra1 = 5'd5;
    expectRd(1, 16'hBEEF, 1'b0, "t3.byp");
    tick();
    re1 = 1'b1; ra1 = 5'd5; re2 = 1'b1; ra2 = 5'd5;
    expectRd(1, 16'hBEEF, 1'b0, "t3.mem");
    expectRd(2, 16'hBEEF, 1'b0, "t3.mem");
    tick();
    tick();
    check("t3.idle.rv1", 16'(rv1), 16'd0);
    check("t3.idle.rd1", rd1, 16'hBEEF);

    // 4: reserve / hazard / resolve
    rsv = 1'b1; rsvA = 5'd7; tick();
    check("t4.busy.set", 16'(anyBusy), 16'd1);
    re1 = 1'b1; ra1 = 5'd7; re2 = 1'b1; ra2 = 5'd7;
    expectRd(1, 16'h0000, 1'b1, "t4.hz");
    expectRd(2, 16'h0000, 1'b1, "t4.hz");
    tick();
    we = 1'b1; wa = 5'd7; wd = 16'h7777; re1 = 1'b1; ra1 = 5'd7;
    expectRd(1, 16'h7777, 1'b0, "t4.resolve");
    tick();
    check("t4.busy.clr", 16'(anyBusy), 16'd0);
    rsv = 1'b1; rsvA = 5'd7; we = 1'b1; wa = 5'd7; wd = 16'h0007; re2 = 1'b1; ra2 = 5'd7;
    expectRd(2, 16'h0007, 1'b0, "t4.tie");
    tick();
    check("t4.busy.tie", 16'(anyBusy), 16'd1);
    re1 = 1'b1; ra1 = 5'd7;
    expectRd(1, 16'h0007, 1'b1, "t4.tie.hz");
    tick();
    we = 1'b1; wa = 5'd7; wd = 16'h0008; tick();
    check("t4.busy.clr2", 16'(anyBusy), 16'd0);
    rsv = 1'b1; rsvA = 5'd8; re1 = 1'b1; ra1 = 5'd8;
    expectRd(1, 16'h0000, 1'b0, "t4.samersv");
    tick();
    re1 = 1'b1; ra1 = 5'd8;
    expectRd(1, 16'h0000, 1'b1, "t4.nextrsv");
    tick();
    we = 1'b1; wa = 5'd8; wd = 16'h0808; tick();
    check("t4.busy.clr3", 16'(anyBusy), 16'd0);

    // 5: hardwired zero and shallow depth
    weZ = 1'b1; waZ = 5'd0; wdZ = 16'hFFFF; tick();
    re1Z = 1'b1; ra1Z = 5'd0;
    expectRd(3, 16'h0000, 1'b0, "t5.zero");
    tick();
    weZ = 1'b1; waZ = 5'd0; wdZ = 16'h1111; re2Z = 1'b1; ra2Z = 5'd0;
    expectRd(4, 16'h0000, 1'b0, "t5.zerobyp");
    tick();
    rsvZ = 1'b1; rsvAZ = 5'd0; tick();
    check("t5.rsv0", 16'(anyBusyZ), 16'd0);
    weZ = 1'b1; waZ = 5'd30; wdZ = 16'h3030; rsvZ = 1'b1; rsvAZ = 5'd30; tick();
    check("t5.rsv30", 16'(anyBusyZ), 16'd0);
    re1Z = 1'b1; ra1Z = 5'd30; re2Z = 1'b1; ra2Z = 5'd23;
    expectRd(3, 16'h0000, 1'b0, "t5.oob");
    expectRd(4, 16'h0000, 1'b0, "t5.last");
    tick();
    weZ = 1'b1; waZ = 5'd23; wdZ = 16'h2323; tick();
    re1Z = 1'b1; ra1Z = 5'd23;
    expectRd(3, 16'h2323, 1'b0, "t5.last.wr");
    tick();

    // 6: reset lands between the read edge and the sample point
    we = 1'b1; wa = 5'd3; wd = 16'hAAAA; rsv = 1'b1; rsvA = 5'd9; tick();
    check("t6.busy", 16'(anyBusy), 16'd1);
    re1 = 1'b1; ra1 = 5'd3;
    @(posedge clk);
    #1;
    check("t6.pre.rd1", rd1, 16'hAAAA);
    reset = 1'b1;
    #1;
    check("t6.rd1", rd1, 16'h0000);
    check("t6.rv1", 16'(rv1), 16'd0);
    check("t6.busy.clr", 16'(anyBusy), 16'd0);
    reset = 1'b0;
    idle();
    re1 = 1'b1; ra1 = 5'd3;
    expectRd(1, 16'h0000, 1'b0, "t6.memclr");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
